// File: rtl/clk_div_pkg.sv
// Shared types, limits and divisor arithmetic for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DIV_W_DEF   = 16;
  localparam int CLK_DIV_MIN = 2;

  typedef enum logic {
    CH_IDLE,
    CH_RUN
  } ch_state_t;

  // Divisors below the minimum would give a zero-length low or high phase.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(CLK_DIV_MIN)) ? 32'(CLK_DIV_MIN) : d;
  endfunction

  // High phase length: ceil(D/2), so odd divisors spend the extra cycle high.
  function automatic logic [31:0] high_len(input logic [31:0] d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, divisor register, div/tick outputs.
// CLK_DIV_GLITCHFREE_EN defers divisor writes to the next period boundary via a shadow register.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
`ifdef CLK_DIV_GLITCHFREE_EN
  output logic             pending,
`endif
  output logic             div,
  output logic             tick
);

  ch_state_t        state_reg, state_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [DIV_W-1:0] d_reg, d_next;
  logic             div_reg, div_next;
  logic             tick_reg, tick_next;
  logic             wrap;

`ifdef CLK_DIV_GLITCHFREE_EN
  logic [DIV_W-1:0] shadow_reg, shadow_next;
  logic             pend_reg, pend_next;
`else
  logic [DIV_W-1:0] ld_div_reg;
  logic             ld_reg;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    d_next     = d_reg;
    wrap       = (state_reg == CH_RUN) && (cnt_reg == d_reg - DIV_W'(1));
`ifdef CLK_DIV_GLITCHFREE_EN
    shadow_next = shadow_reg;
    pend_next   = pend_reg;
    if (!en) begin
      state_next = CH_IDLE;
      cnt_next   = '0;
      if (pend_reg) begin
        d_next    = shadow_reg;
        pend_next = 1'b0;
      end
      if (wr) begin
        shadow_next = wr_div;
        pend_next   = 1'b1;
      end
    end else if (state_reg == CH_IDLE || wrap) begin
      // Period boundary: a write landing here is applied without waiting.
      state_next = CH_RUN;
      cnt_next   = '0;
      if (wr) begin
        d_next    = wr_div;
        pend_next = 1'b0;
      end else if (pend_reg) begin
        d_next    = shadow_reg;
        pend_next = 1'b0;
      end
    end else begin
      cnt_next = cnt_reg + DIV_W'(1);
      if (wr) begin
        shadow_next = wr_div;
        pend_next   = 1'b1;
      end
    end
`else
    if (ld_reg) begin
      // Immediate restart: one low cycle, then a fresh period.
      d_next     = ld_div_reg;
      cnt_next   = '0;
      state_next = CH_IDLE;
    end else if (!en) begin
      cnt_next   = '0;
      state_next = CH_IDLE;
    end else if (state_reg == CH_IDLE || wrap) begin
      cnt_next   = '0;
      state_next = CH_RUN;
    end else begin
      cnt_next = cnt_reg + DIV_W'(1);
    end
`endif
    div_next  = (state_next == CH_RUN) && (32'(cnt_next) < high_len(32'(d_next)));
    tick_next = (state_next == CH_RUN) && (cnt_next == d_next - DIV_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CH_IDLE;
      cnt_reg   <= '0;
      d_reg     <= DIV_W'(DIV_RST);
      div_reg   <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      d_reg     <= d_next;
      div_reg   <= div_next;
      tick_reg  <= tick_next;
    end
  end

`ifdef CLK_DIV_GLITCHFREE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg <= '0;
      pend_reg   <= 1'b0;
    end else begin
      shadow_reg <= shadow_next;
      pend_reg   <= pend_next;
    end
  end

  assign pending = pend_reg;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_reg     <= 1'b0;
      ld_div_reg <= '0;
    end else begin
      ld_reg     <= wr;
      ld_div_reg <= wr_div;
    end
  end
`endif

  assign div  = div_reg;
  assign tick = tick_reg;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel divider top: write handshake, channel decode and CH_NUM divider channels.
// CLK_DIV_GLITCHFREE_EN makes cfg_ready reflect the selected channel's pending shadow write.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CH_NUM  = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DIV_RST = 50
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [CH_NUM-1:0]                           en,
  input  logic                                        cfg_valid,
  output logic                                        cfg_ready,
  input  logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]                            cfg_div,
  output logic [CH_NUM-1:0]                           div,
  output logic [CH_NUM-1:0]                           tick
);

  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic              ready_reg;
  logic              accept;
  logic [DIV_W-1:0]  wr_div;
  logic [CH_NUM-1:0] wr_ch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_reg <= 1'b0;
    else     ready_reg <= 1'b1;
  end

`ifdef CLK_DIV_GLITCHFREE_EN
  logic [CH_NUM-1:0] pending;
  logic              pend_sel;

  // Out-of-range channels never block, so writes to them are simply dropped.
  always_comb begin
    pend_sel = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cfg_ch == CH_W'(i)) pend_sel = pending[i];
    end
  end

  assign cfg_ready = ready_reg && !pend_sel;
`else
  assign cfg_ready = ready_reg;
`endif

  assign accept = cfg_valid && cfg_ready;
  assign wr_div = DIV_W'(clamp_div(32'(cfg_div)));

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    assign wr_ch[gi] = accept && (cfg_ch == CH_W'(gi));

    clk_div_ch #(
      .DIV_W  (DIV_W),
      .DIV_RST(DIV_RST)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[gi]),
      .wr     (wr_ch[gi]),
      .wr_div (wr_div),
`ifdef CLK_DIV_GLITCHFREE_EN
      .pending(pending[gi]),
`endif
      .div    (div[gi]),
      .tick   (tick[gi])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi (default build): two instances (4 and 3 channels) against a
// timestamp-based reference of each channel's period, under directed and random stimulus.
module tb_clk_div_multi;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        ready_a, ready_b;
  logic [3:0]  div_a, tick_a;
  logic [2:0]  div_b, tick_b;

  clk_div_multi #(.CH_NUM(4), .DIV_W(16), .DIV_RST(50)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(ready_a),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .div(div_a), .tick(tick_a)
  );

  clk_div_multi #(.CH_NUM(3), .DIV_W(16), .DIV_RST(6)) u_dut_b (
    .clk(clk), .rst(rst), .en(en[2:0]), .cfg_valid(cfg_valid), .cfg_ready(ready_b),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .div(div_b), .tick(tick_b)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // Reference: each running channel remembers the edge its period train started (t0)
  // and its divisor; the wave is then a pure function of (t - t0) mod D.
  int nch[2]  = '{4, 3};
  int rstv[2] = '{50, 6};
  int m_d[2][8];
  int m_t0[2][8];
  int m_ldt[2][8];
  int m_ldv[2][8];
  bit m_rdy[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h edge=%0d", tag, got, exp, t);
    end
  endtask

  task automatic model_reset(input int i);
    for (int c = 0; c < 8; c++) begin
      m_d[i][c]   = rstv[i];
      m_t0[i][c]  = -1;
      m_ldt[i][c] = -10;
      m_ldv[i][c] = 0;
    end
    m_rdy[i] = 1'b0;
  endtask

  task automatic step();
    logic [7:0] ed, et;
    int ph;
    @(posedge clk);
    #1;
    t++;
    for (int i = 0; i < 2; i++) begin
      ed = '0;
      et = '0;
      if (rst) begin
        model_reset(i);
      end else begin
        for (int c = 0; c < nch[i]; c++) begin
          if (m_ldt[i][c] == t) begin
            m_d[i][c]  = m_ldv[i][c];
            m_t0[i][c] = -1;
          end else if (!en[c]) begin
            m_t0[i][c] = -1;
          end else begin
            if (m_t0[i][c] < 0) m_t0[i][c] = t;
            ph    = (t - m_t0[i][c]) % m_d[i][c];
            ed[c] = (ph < (m_d[i][c] + 1) / 2);
            et[c] = (ph == m_d[i][c] - 1);
          end
        end
        if (cfg_valid && m_rdy[i] && int'(cfg_ch) < nch[i]) begin
          m_ldt[i][cfg_ch] = t + 1;
          m_ldv[i][cfg_ch] = (cfg_div < 16'd2) ? 2 : int'(cfg_div);
        end
        m_rdy[i] = 1'b1;
      end
      if (i == 0) begin
        chk("a.div",  32'(div_a),   32'(ed[3:0]));
        chk("a.tick", 32'(tick_a),  32'(et[3:0]));
        chk("a.rdy",  32'(ready_a), 32'(m_rdy[0]));
      end else begin
        chk("b.div",  32'(div_b),   32'(ed[2:0]));
        chk("b.tick", 32'(tick_b),  32'(et[2:0]));
        chk("b.rdy",  32'(ready_b), 32'(m_rdy[1]));
      end
    end
  endtask

  task automatic write(input logic [1:0] ch, input logic [15:0] d);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = d;
    step();
    cfg_valid = 1'b0;
  endtask

  // Step until the reference shows channel c of instance A at period phase ph.
  task automatic wait_phase(input int c, input int ph, input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      step();
      if (m_t0[0][c] >= 0 && (t - m_t0[0][c]) % m_d[0][c] == ph) break;
    end
    if (k == 200) chk(tag, 32'd0, 32'd1);
  endtask

  int cnt_hi, cnt_tk;

  initial begin
    rst       = 1'b1;
    en        = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    model_reset(0);
    model_reset(1);

    repeat (50) step();
    rst = 1'b0;

    // Default divisor on ch0: 25 high + 25 low, one tick per 50 cycles.
    en = 4'b0001;
    cnt_hi = 0;
    cnt_tk = 0;
    repeat (100) begin
      step();
      cnt_hi += int'(div_a[0]);
      cnt_tk += int'(tick_a[0]);
    end
    chk("a.ch0.high_in_100", 32'(cnt_hi), 32'd50);
    chk("a.ch0.ticks_in_100", 32'(cnt_tk), 32'd2);

    // Odd divisor on ch1.
    en = 4'b0000;
    write(2'd1, 16'd5);
    en = 4'b0010;
    repeat (20) step();

    // Clamp 0/1 to 2 on ch2; cfg_ch=3 is out of range for the 3-channel instance.
    write(2'd2, 16'd0);
    write(2'd2, 16'd1);
    en = 4'b0110;
    write(2'd3, 16'd9);
    repeat (16) step();

    // Mid-period divisor change on ch0.
    write(2'd0, 16'd10);
    en = 4'b0001;
    wait_phase(0, 2, "a.wait_ch0_cnt2");
    write(2'd0, 16'd4);
    repeat (12) step();

    // Drop en3 mid-high, re-enable 7 cycles later.
    write(2'd3, 16'd8);
    en = 4'b1000;
    wait_phase(3, 1, "a.wait_ch3_high");
    en = 4'b0000;
    repeat (7) step();
    en = 4'b1000;
    repeat (20) step();

    // Random traffic.
    repeat (2000) begin
      if ($urandom_range(0, 15) == 0) en = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = 2'($urandom);
        cfg_div   = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 60))
                                                 : 16'($urandom_range(0, 9));
      end else begin
        cfg_valid = 1'b0;
      end
      step();
    end
    cfg_valid = 1'b0;

    // Asynchronous reset in the middle of a cycle, then D must be back to 50.
    write(2'd0, 16'd7);
    en = 4'b1111;
    repeat (13) step();
    #4;
    rst = 1'b1;
    #1;
    chk("a.async_div",  32'(div_a),   32'd0);
    chk("a.async_tick", 32'(tick_a),  32'd0);
    chk("a.async_rdy",  32'(ready_a), 32'd0);
    chk("b.async_div",  32'(div_b),   32'd0);
    chk("b.async_tick", 32'(tick_b),  32'd0);
    repeat (3) step();
    rst = 1'b0;
    en  = 4'b0001;
    cnt_hi = 0;
    repeat (50) begin
      step();
      cnt_hi += int'(div_a[0]);
    end
    chk("a.ch0.high_after_rst", 32'(cnt_hi), 32'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
